ntsc_timing: RTL and testbench
==============================

Name: ntsc_timing

Overview:
- Free-running NTSC-style 240-line progressive (240p) raster timing generator for a 50 MHz system clock.
- Divides the clock down to a pixel-rate enable and runs horizontal and vertical pixel/line counters.
- Decodes active-video, horizontal-sync and vertical-sync from the counters.
- Sits between the system clock/reset and the pixel-generation and DAC/sync-output logic, which consume x/y/video_on.

Parameters:
- CLK_DIV, 5, system clocks per pixel (50 MHz / 5 = 10 MHz pixel rate); legal range >= 2.
- H_ACTIVE, 512, visible pixels per line.
- H_FRONT, 15, horizontal front porch, in pixels.
- H_SYNC, 47, hsync pulse width, in pixels (4.7 us).
- H_BACK, 61, horizontal back porch, in pixels; H_TOTAL = 635 (63.5 us).
- V_ACTIVE, 240, visible lines.
- V_FRONT, 3, vertical front porch, in lines.
- V_SYNC, 3, vsync width, in lines.
- V_BACK, 16, vertical back porch, in lines; V_TOTAL = 262.

Ports:
- clk  in  1  system clock, 50 MHz, rising-edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset.
- x  out  10  horizontal pixel counter, 0..H_TOTAL-1.
- y  out  9  vertical line counter, 0..V_TOTAL-1.
- video_on  out  1  high while (x,y) is inside the visible area.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- pixel_tick  out  1  one-clock pulse per pixel period; high in the cycle that advances x.

Behaviour:
- Reset (rst=0, asynchronous): divider count=0, x=0, y=0, pixel_tick=0. Decoded outputs follow x=y=0, so video_on=1, hsync=1, vsync=1.
- Divider: counts 0..CLK_DIV-1 and wraps. pixel_tick = (count == CLK_DIV-1), decoded combinationally from the registered count. First tick occurs in the CLK_DIV-th clock after reset release.
- x update: on a clock edge with pixel_tick=1, x increments. x = H_TOTAL-1 wraps to 0. No change when pixel_tick=0.
- y update: increments on the same edge on which x wraps. y = V_TOTAL-1 together with an x wrap takes y to 0, giving (x,y) = (0,0) as the frame wrap.
- video_on = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync = 0 iff H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, i.e. x in 527..573.
- vsync = 0 iff V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC, i.e. y in 243..245. vsync is line-granular and changes only on the x wrap.
- video_on, hsync and vsync are combinational decodes of the registered x/y: zero latency relative to x/y and glitch-free because they are derived from registers only.
- Counter widths: x is 10 bits and y is 9 bits. Any parameter set whose H_TOTAL exceeds 1024 or V_TOTAL exceeds 512 is illegal. Counters never hold out-of-range values.
- Reset asserted mid-line or mid-frame forces all state back to the reset values immediately. Timing restarts from (0,0) after release; no partial-line recovery.
- No inputs other than clk/rst; the block free-runs indefinitely.

Optional Feature:
- Macro: NTSC_CSYNC_EN.
- Defined: adds output port csync (1 bit, active-low composite sync), csync = ~(hsync ^ vsync). This gives serration-style inverted hsync pulses during the vsync lines.
- Undefined: port csync is absent; all other behaviour is identical.

Decomposition:
- Package ntsc_pkg holds:
  - default timing constants (H_ACTIVE..V_BACK, CLK_DIV);
  - derived H_TOTAL/V_TOTAL and sync start/end localparams;
  - counter width constants (10, 9).
- Sub-module ntsc_tick_div: parameterised CLK_DIV clock-enable divider with clk, rst, tick. It is instantiated once.
- Counters and sync decode stay in ntsc_timing.

Test Plan:
- Reset: hold rst=0 for 3 clocks -> x=0, y=0, video_on=1, hsync=1, vsync=1, pixel_tick=0. Release -> pixel_tick first high in the 5th clock after release; x becomes 1 on that edge.
- Tick cadence: run 100 clocks -> pixel_tick high exactly 1 in every 5 clocks; x = 20 after 100 clocks from release.
- Horizontal decode over one line, 3175 clocks:
  - video_on falls at x=512;
  - hsync low for x=527..573 (235 clocks), high again at x=574;
  - x goes 634 -> 0 and y goes 0 -> 1 on the same edge.
- Vertical decode:
  - vsync low for exactly lines y=243..245;
  - video_on=0 for all y >= 240;
  - at y=261, x=634 the next tick gives x=0, y=0.
- Mid-operation reset: assert rst=0 at x=300, y=5 -> outputs return to reset values asynchronously, before the next clock edge. After release the timing is identical to a cold start.
- NTSC_CSYNC_EN defined: csync = 0 during the hsync pulse on y=10; csync = 1 during the hsync pulse on y=244 and = 0 elsewhere on that line.

Source files
------------

// File: rtl/ntsc_pkg.sv
// Default 240p NTSC raster constants and counter widths shared by the ntsc_timing block.
// The ntsc_timing top adds a composite-sync output when NTSC_CSYNC_EN is defined.
package ntsc_pkg;

    localparam int CLK_DIV  = 5;

    localparam int H_ACTIVE = 512;
    localparam int H_FRONT  = 15;
    localparam int H_SYNC   = 47;
    localparam int H_BACK   = 61;

    localparam int V_ACTIVE = 240;
    localparam int V_FRONT  = 3;
    localparam int V_SYNC   = 3;
    localparam int V_BACK   = 16;

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are half-open: [START, END)
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int X_W      = 10;
    localparam int Y_W      = 9;

endpackage

// File: rtl/ntsc_tick_div.sv
// Clock-enable divider: tick is high for one clock out of every CLK_DIV clocks.
module ntsc_tick_div #(
    parameter int CLK_DIV = ntsc_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ntsc_timing.sv
// Free-running 240p raster generator: pixel/line counters plus video_on, hsync, vsync decode.
// Defining NTSC_CSYNC_EN adds the active-low composite sync output csync.
module ntsc_timing
    import ntsc_pkg::*;
#(
    parameter int CLK_DIV  = ntsc_pkg::CLK_DIV,
    parameter int H_ACTIVE = ntsc_pkg::H_ACTIVE,
    parameter int H_FRONT  = ntsc_pkg::H_FRONT,
    parameter int H_SYNC   = ntsc_pkg::H_SYNC,
    parameter int H_BACK   = ntsc_pkg::H_BACK,
    parameter int V_ACTIVE = ntsc_pkg::V_ACTIVE,
    parameter int V_FRONT  = ntsc_pkg::V_FRONT,
    parameter int V_SYNC   = ntsc_pkg::V_SYNC,
    parameter int V_BACK   = ntsc_pkg::V_BACK
) (
    input  logic           clk,
    input  logic           rst,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           video_on,
    output logic           hsync,
    output logic           vsync,
    output logic           pixel_tick
`ifdef NTSC_CSYNC_EN
    ,
    output logic           csync
`endif
);

    // Totals must fit the counters: at most 1024 pixels and 512 lines
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [X_W-1:0] X_ACT  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_ACT  = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_LO  = X_W'(H_ACTIVE + H_FRONT);
    localparam logic [X_W-1:0] HS_HI  = X_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [Y_W-1:0] VS_LO  = Y_W'(V_ACTIVE + V_FRONT);
    localparam logic [Y_W-1:0] VS_HI  = Y_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic           tick;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    ntsc_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Decodes come straight from registers, so they are glitch-free with no added latency
    assign x          = x_q;
    assign y          = y_q;
    assign pixel_tick = tick;
    assign video_on   = (x_q < X_ACT) && (y_q < Y_ACT);
    assign hsync      = !((x_q >= HS_LO) && (x_q < HS_HI));
    assign vsync      = !((y_q >= VS_LO) && (y_q < VS_HI));

`ifdef NTSC_CSYNC_EN
    assign csync      = ~(hsync ^ vsync);
`endif

endmodule

// File: tb/tb_ntsc_timing.sv
// Directed bench for ntsc_timing: default-timing DUT plus a short-line DUT to reach the vertical edges quickly.
// csync checks are compiled in only when NTSC_CSYNC_EN is defined.
module tb_ntsc_timing;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [9:0] mX;
    logic [8:0] mY;
    logic       mVid, mHs, mVs, mTick;
    logic [9:0] sX;
    logic [8:0] sY;
    logic       sVid, sHs, sVs, sTick;
`ifdef NTSC_CSYNC_EN
    logic       mCsync, sCsync;
`endif

    int vectorCount = 0;
    int missCount   = 0;
    int k           = 0;
    int tickTally   = 0;
    int hsLowMain   = 0;
    int vsLowSmall  = 0;

    always #10 clk = ~clk;

    ntsc_timing dutMain (
        .clk       (clk),
        .rst       (rst),
        .x         (mX),
        .y         (mY),
        .video_on  (mVid),
        .hsync     (mHs),
        .vsync     (mVs),
        .pixel_tick(mTick)
`ifdef NTSC_CSYNC_EN
        ,
        .csync     (mCsync)
`endif
    );

    // Eight-pixel lines at CLK_DIV=2 give a 4192-clock frame with the default vertical timing
    ntsc_timing #(
        .CLK_DIV (2),
        .H_ACTIVE(4),
        .H_FRONT (1),
        .H_SYNC  (2),
        .H_BACK  (1)
    ) dutSmall (
        .clk       (clk),
        .rst       (rst),
        .x         (sX),
        .y         (sY),
        .video_on  (sVid),
        .hsync     (sHs),
        .vsync     (sVs),
        .pixel_tick(sTick)
`ifdef NTSC_CSYNC_EN
        ,
        .csync     (sCsync)
`endif
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s (k=%0d): got %0d, expected %0d", tag, k, observed, expected);
        end
    endtask

    // Expected raster position is k clocks after reset release, sampled on the falling edge
    task automatic checkModel();
        int p, ex, ey, eHs, eVs;
        p   = k / 5;
        ex  = p % 635;
        ey  = (p / 635) % 262;
        eHs = (ex >= 527 && ex < 574) ? 0 : 1;
        eVs = (ey >= 243 && ey < 246) ? 0 : 1;
        checkOutput("main.tick",  int'(mTick), (k % 5 == 4) ? 1 : 0);
        checkOutput("main.x",     int'(mX), ex);
        checkOutput("main.y",     int'(mY), ey);
        checkOutput("main.video", int'(mVid), (ex < 512 && ey < 240) ? 1 : 0);
        checkOutput("main.hsync", int'(mHs), eHs);
        checkOutput("main.vsync", int'(mVs), eVs);
`ifdef NTSC_CSYNC_EN
        checkOutput("main.csync", int'(mCsync), (eHs == eVs) ? 1 : 0);
`endif
        p   = k / 2;
        ex  = p % 8;
        ey  = (p / 8) % 262;
        eHs = (ex >= 5 && ex < 7) ? 0 : 1;
        eVs = (ey >= 243 && ey < 246) ? 0 : 1;
        checkOutput("small.tick",  int'(sTick), (k % 2 == 1) ? 1 : 0);
        checkOutput("small.x",     int'(sX), ex);
        checkOutput("small.y",     int'(sY), ey);
        checkOutput("small.video", int'(sVid), (ex < 4 && ey < 240) ? 1 : 0);
        checkOutput("small.hsync", int'(sHs), eHs);
        checkOutput("small.vsync", int'(sVs), eVs);
`ifdef NTSC_CSYNC_EN
        checkOutput("small.csync", int'(sCsync), (eHs == eVs) ? 1 : 0);
`endif
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge clk);
            k++;
            checkModel();
            if (k <= 100 && mTick)   tickTally++;
            if (k <= 3175 && !mHs)   hsLowMain++;
            if (k <= 4192 && !sVs)   vsLowSmall++;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".x"},     int'(mX), 0);
        checkOutput({tag, ".y"},     int'(mY), 0);
        checkOutput({tag, ".video"}, int'(mVid), 1);
        checkOutput({tag, ".hsync"}, int'(mHs), 1);
        checkOutput({tag, ".vsync"}, int'(mVs), 1);
        checkOutput({tag, ".tick"},  int'(mTick), 0);
    endtask

    initial begin
        $display("[TB] ntsc_timing bench start");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");

        rst = 1'b1;
        k   = 0;
        applyStimulus(4);
        checkOutput("cold.firstTick", int'(mTick), 1);
        checkOutput("cold.xBeforeTick", int'(mX), 0);
        applyStimulus(1);
        checkOutput("cold.xAfterTick", int'(mX), 1);
        applyStimulus(95);
        checkOutput("cadence.x100", int'(mX), 20);
        checkOutput("cadence.ticks", tickTally, 20);

        applyStimulus(3174 - 100);
        checkOutput("line.xLast", int'(mX), 634);
        checkOutput("line.yBefore", int'(mY), 0);
        applyStimulus(1);
        checkOutput("line.xWrap", int'(mX), 0);
        checkOutput("line.yAfter", int'(mY), 1);
        checkOutput("line.hsyncLowClocks", hsLowMain, 235);

        applyStimulus(4191 - 3175);
        checkOutput("frame.xLast", int'(sX), 7);
        checkOutput("frame.yLast", int'(sY), 261);
        checkOutput("frame.vsyncLowClocks", vsLowSmall, 48);
        applyStimulus(1);
        checkOutput("frame.xWrap", int'(sX), 0);
        checkOutput("frame.yWrap", int'(sY), 0);

        applyStimulus(17376 - 4192);
        checkOutput("mid.x", int'(mX), 300);
        checkOutput("mid.y", int'(mY), 5);
        #2 rst = 1'b0;
        #1 checkResetState("asyncReset");
        @(negedge clk);
        @(negedge clk);
        checkResetState("heldReset");

        rst = 1'b1;
        k   = 0;
        applyStimulus(4);
        checkOutput("restart.firstTick", int'(mTick), 1);
        applyStimulus(1);
        checkOutput("restart.xAfterTick", int'(mX), 1);
        applyStimulus(95);
        checkOutput("restart.x100", int'(mX), 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
